// File: rtl/temporizador_pkg.sv
// Shared types and helpers for the multi-channel timer.
package temporizador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } state_t;

    // Bits needed to hold values 0..n-1 (at least 1).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int i = 0; i < 32; i++) begin
            if (((n - 1) >> i) != 0) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/temporizador_multi_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every PRESCALE cycles.
module tick_gen
    import temporizador_pkg::*;
#(
    parameter int unsigned PRESCALE = 100000000
) (
    input  logic clk_100MHz,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned PW = clog2(PRESCALE);
    localparam logic [PW-1:0] LAST     = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 2);

    logic [PW-1:0] presc;

    // tick is registered one cycle ahead so it is high while presc sits at LAST
    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            presc <= (presc == LAST) ? '0 : presc + PW'(1);
            tick  <= (presc == PRE_LAST);
        end
    end

endmodule

// File: rtl/temporizador_multi.sv
// Multi-channel down-counting timer sharing one seconds-tick prescaler.
module temporizador_multi
    import temporizador_pkg::*;
#(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 100000000
) (
    input  logic                      clk_100MHz,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] value,
    input  logic [CHANNELS-1:0]       start_timer,
    input  logic [CHANNELS-1:0]       cancel,
    input  logic [CHANNELS-1:0]       pause,
    output logic [CHANNELS-1:0]       t_expired,
    output logic [CHANNELS-1:0]       on,
    output logic [CHANNELS-1:0]       counting,
    output logic [CHANNELS*WIDTH-1:0] counter,
    output logic                      tick
);

    tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .tick       (tick)
    );

    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
        state_t           state, state_next;
        logic [WIDTH-1:0] cnt, cnt_next, load;
        logic             exp_q, exp_next, on_q, counting_q;

        assign load = value[i*WIDTH +: WIDTH];

        // Priority: cancel > start_timer > pause > tick
        always_comb begin
            state_next = state;
            cnt_next   = cnt;
            exp_next   = 1'b0;
            if (cancel[i]) begin
                state_next = IDLE;
                cnt_next   = '0;
            end else if (start_timer[i]) begin
                if (load == '0) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    exp_next   = 1'b1;
                end else begin
                    cnt_next   = load;
                    state_next = pause[i] ? HOLD : RUN;
                end
            end else begin
                case (state)
                    RUN: begin
                        if (pause[i]) begin
                            state_next = HOLD;
                        end else if (tick) begin
                            if (cnt <= WIDTH'(1)) begin
                                state_next = IDLE;
                                cnt_next   = '0;
                                exp_next   = 1'b1;
                            end else begin
                                cnt_next = cnt - WIDTH'(1);
                            end
                        end
                    end
                    HOLD: begin
                        if (!pause[i]) begin
                            state_next = RUN;
                        end
                    end
                    default: begin
                        state_next = IDLE;
                    end
                endcase
            end
        end

        always_ff @(posedge clk_100MHz) begin
            if (!rst_n) begin
                state      <= IDLE;
                cnt        <= '0;
                exp_q      <= 1'b0;
                on_q       <= 1'b0;
                counting_q <= 1'b0;
            end else begin
                state      <= state_next;
                cnt        <= cnt_next;
                exp_q      <= exp_next;
                on_q       <= (state_next != IDLE);
                counting_q <= (state_next == RUN);
            end
        end

        assign t_expired[i]                = exp_q;
        assign on[i]                       = on_q;
        assign counting[i]                 = counting_q;
        assign counter[i*WIDTH +: WIDTH]   = cnt;
    end

endmodule

// File: tb/tb_temporizador_multi.sv
// Scoreboard bench for temporizador_multi against a behavioural channel model.
module tb_temporizador_multi;

    localparam int unsigned CH = 2;
    localparam int unsigned W  = 4;
    localparam int unsigned P  = 4;

    logic              clk_100MHz = 1'b0;
    logic              rst_n;
    logic [CH*W-1:0]   value;
    logic [CH-1:0]     start_timer, cancel, pause;
    logic [CH-1:0]     t_expired, on, counting;
    logic [CH*W-1:0]   counter;
    logic              tick;

    always #5 clk_100MHz = ~clk_100MHz;

    temporizador_multi #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(P)) dut (
        .clk_100MHz  (clk_100MHz),
        .rst_n       (rst_n),
        .value       (value),
        .start_timer (start_timer),
        .cancel      (cancel),
        .pause       (pause),
        .t_expired   (t_expired),
        .on          (on),
        .counting    (counting),
        .counter     (counter),
        .tick        (tick)
    );

    typedef struct packed {
        logic [CH-1:0]   exp_f;
        logic [CH-1:0]   on_f;
        logic [CH-1:0]   cnt_f;
        logic [CH*W-1:0] ctr;
        logic            tk;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   armed = 0;
    bit   done  = 0;

    // Behavioural model: cycles since reset, remaining ticks, loaded/running flags
    int m_cyc;
    int m_rem [CH];
    bit m_ld  [CH];
    bit m_run [CH];

    task automatic step(input logic r, input logic [CH-1:0] st, input logic [CH-1:0] ca,
                        input logic [CH-1:0] pa, input logic [CH*W-1:0] v);
        exp_t e;
        bit   tk_now;
        int   vv;
        @(negedge clk_100MHz);
        rst_n = r; start_timer = st; cancel = ca; pause = pa; value = v;
        e = '0;
        if (!r) begin
            m_cyc = 0;
            for (int c = 0; c < CH; c++) begin
                m_rem[c] = 0; m_ld[c] = 0; m_run[c] = 0;
            end
        end else begin
            tk_now = (m_cyc == P - 1);
            for (int c = 0; c < CH; c++) begin
                vv = int'(v[c*W +: W]);
                if (ca[c]) begin
                    m_ld[c] = 0; m_run[c] = 0; m_rem[c] = 0;
                end else if (st[c]) begin
                    if (vv == 0) begin
                        m_ld[c] = 0; m_run[c] = 0; m_rem[c] = 0; e.exp_f[c] = 1'b1;
                    end else begin
                        m_ld[c] = 1; m_run[c] = !pa[c]; m_rem[c] = vv;
                    end
                end else if (m_ld[c] && m_run[c]) begin
                    if (pa[c]) begin
                        m_run[c] = 0;
                    end else if (tk_now) begin
                        m_rem[c] = m_rem[c] - 1;
                        if (m_rem[c] == 0) begin
                            m_ld[c] = 0; m_run[c] = 0; e.exp_f[c] = 1'b1;
                        end
                    end
                end else if (m_ld[c] && !pa[c]) begin
                    m_run[c] = 1;
                end
            end
            m_cyc = (m_cyc + 1) % P;
        end
        for (int c = 0; c < CH; c++) begin
            e.on_f[c]        = m_ld[c];
            e.cnt_f[c]       = m_ld[c] && m_run[c];
            e.ctr[c*W +: W]  = W'(m_rem[c]);
        end
        e.tk = (m_cyc == P - 1);
        q.push_back(e);
        armed = 1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, '0, '0, '0, '0);
    endtask

    task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] x);
        n_cmp++;
        if (a !== x) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, a, x, $time);
        end
    endtask

    // Monitor: compare registered outputs just after every active edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_100MHz);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("t_expired", 8'(t_expired), 8'(e.exp_f));
                chk("on",        8'(on),        8'(e.on_f));
                chk("counting",  8'(counting),  8'(e.cnt_f));
                chk("counter",   8'(counter),   8'(e.ctr));
                chk("tick",      8'(tick),      8'(e.tk));
            end else if (armed && !done) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard_empty: got no expectation, expected one at %0t", $time);
            end
        end
    end

    initial begin
        logic [CH-1:0]   pl;
        logic [CH-1:0]   st, ca;
        logic [CH*W-1:0] v;
        logic            r;
        rst_n = 1'b0; value = '0; start_timer = '0; cancel = '0; pause = '0;
        pl = '0;

        // Reset with random inputs, then watch the free-running tick
        for (int k = 0; k < 3; k++)
            step(1'b0, CH'($urandom), CH'($urandom), CH'($urandom), (CH*W)'($urandom));
        idle(12);

        // Basic expiry
        step(1'b1, 2'b01, 2'b00, 2'b00, 8'h03);
        idle(16);

        // Pause across two ticks
        step(1'b1, 2'b01, 2'b00, 2'b00, 8'h05);
        idle(2);
        for (int k = 0; k < 9; k++) step(1'b1, 2'b00, 2'b00, 2'b01, 8'h00);
        idle(30);

        // Restart while counter is 2, then cancel together with start
        step(1'b1, 2'b01, 2'b00, 2'b00, 8'h03);
        for (int k = 0; k < 40 && m_rem[0] != 2; k++) idle(1);
        step(1'b1, 2'b01, 2'b00, 2'b00, 8'h07);
        idle(3);
        step(1'b1, 2'b01, 2'b01, 2'b00, 8'h07);
        idle(3);

        // Zero value on channel 1
        step(1'b1, 2'b10, 2'b00, 2'b00, 8'h00);
        idle(2);

        // Concurrent channels, then reset mid-run
        step(1'b1, 2'b11, 2'b00, 2'b00, 8'h42);
        idle(24);
        step(1'b1, 2'b01, 2'b00, 2'b00, 8'h05);
        idle(6);
        step(1'b0, 2'b00, 2'b00, 2'b00, 8'h00);
        step(1'b0, 2'b00, 2'b00, 2'b00, 8'h00);
        idle(3);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(99) != 0);
            v = (CH*W)'($urandom);
            for (int c = 0; c < CH; c++) begin
                st[c] = ($urandom_range(7) == 0);
                ca[c] = ($urandom_range(15) == 0);
                if ($urandom_range(9) == 0) pl[c] = ~pl[c];
                if ($urandom_range(7) == 0) v[c*W +: W] = '0;
            end
            step(r, st, ca, pl, v);
        end
        idle(2);

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk_100MHz);
        if (q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
